mmio_dma_map: RTL and testbench
===============================

MMIO_DMA_MAP -- requirements
Module: mmio_dma_map

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of memory words, registers and the data bus.
REQ-002 SHALL have parameter ADDR_W, default 5: memory depth is 2**ADDR_W words.
REQ-003 SHALL have parameter CTRL_BASE, default 16: base address of the 5-word control window. Legal range is CTRL_BASE+4 < 2**ADDR_W.
REQ-004 SHALL have port: clk  input  1  rising-edge clock.
REQ-005 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port: wr  input  1  CPU write strobe.
REQ-007 SHALL have port: addr  input  ADDR_W  CPU address.
REQ-008 SHALL have port: data_i  input  DATA_W  CPU write data.
REQ-009 SHALL have port: data_o  output  DATA_W  CPU read data.
REQ-010 SHALL have port: irq  output  1  DMA completion interrupt.
REQ-011 SHALL have port: busy  output  1  DMA transfer in progress.

Function
REQ-012 SHALL map the register window as follows; all other addresses are plain memory words.
- CTRL at CTRL_BASE+0: bit0 START (write-1 pulse, always reads 0); bit1 IRQ_EN.
- STATUS at +1: bit0 BUSY (read-only); bit1 DONE (sticky, write-1-to-clear).
- SRC at +2, DST at +3, LEN at +4.
REQ-013 SHALL implement the register window as dedicated flops. Memory words shadowed by the window are never read or written.
REQ-014 SHALL drive data_o combinationally: the register value when addr is in the window, otherwise mem[addr]. Unused register bits read 0.
REQ-015 SHALL commit CPU writes on the rising clk edge where wr=1.
REQ-016 SHALL run the DMA FSM through states IDLE, RD, WR and DONE.
REQ-017 In IDLE, a CPU write of START=1 with LEN!=0 SHALL do the following on that edge, then go to RD:
- load src_ptr=SRC, dst_ptr=DST, cnt=LEN;
- clear DONE.
REQ-018 In IDLE, a CPU write of START=1 with LEN==0 SHALL go directly to DONE with no memory access.
REQ-019 In RD, the FSM SHALL latch mem[src_ptr] into a buffer and go to WR. A src_ptr inside the window SHALL read as 0.
REQ-020 In WR, the FSM SHALL do the following, then go to DONE if cnt was 1, else to RD:
- write the buffer to mem[dst_ptr];
- increment src_ptr and dst_ptr modulo 2**ADDR_W;
- decrement cnt.
REQ-021 A DMA write whose dst_ptr falls inside the window SHALL be dropped, while pointers and cnt still advance.
REQ-022 When a CPU write (wr=1) coincides with WR, the CPU SHALL take priority. The DMA SHALL stay in WR with its pointers unchanged and retry on the next cycle.
REQ-023 DONE SHALL set STATUS.DONE and return to IDLE on the next edge.
REQ-024 Throughput SHALL be 2 cycles per word with no stalls. busy SHALL be high for exactly 2*LEN+1 cycles, from the edge after START to the return to IDLE.
REQ-025 busy SHALL be 1 in RD, WR and DONE, and 0 in IDLE.
REQ-026 A START write while busy=1 SHALL be ignored. SRC, DST and LEN writes while busy=1 SHALL be ignored. IRQ_EN and DONE-clear writes SHALL always be accepted.
REQ-027 irq SHALL equal STATUS.DONE AND CTRL.IRQ_EN as a level, held until software clears DONE or IRQ_EN.
REQ-028 If a DONE-clear write coincides with the DONE state, the set SHALL win.
REQ-029 Overlapping source and destination ranges SHALL be copied strictly in ascending word order, with no special handling.

Reset
REQ-030 While reset=1, all of the following SHALL hold asynchronously:
- every memory word = 0;
- SRC, DST, LEN, IRQ_EN, DONE = 0;
- FSM = IDLE, cnt and pointers = 0;
- irq = 0, busy = 0.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer. Words already written stay cleared by reset, and DONE is not set.

Verification
REQ-032 Bench SHALL cover the basic copy: write mem[0..2]=A1,B2,C3, SRC=0, DST=8, LEN=3, CTRL=3. Required response: busy for 7 cycles, mem[8..10]=A1,B2,C3, DONE=1, irq=1; writing STATUS=2 then drops irq to 0.
REQ-033 Bench SHALL cover LEN=0: START gives busy for 1 cycle, DONE=1, and no memory change.
REQ-034 Bench SHALL cover wrap-around: SRC=30, DST=4, LEN=3 with mem[30]=11, mem[31]=22, mem[0]=33. Required response: mem[4..6]=11,22,33.
REQ-035 Bench SHALL cover CPU collision: a CPU write to mem[12]=55 on the first WR cycle of a LEN=2 copy. Required response: mem[12]=55, the copy completes correctly, and busy stretches to 6 cycles.
REQ-036 Bench SHALL cover window protection and busy lockout: DST=CTRL_BASE-1, LEN=3 leaves the register window unchanged; writing SRC during busy leaves SRC unchanged.
REQ-037 Bench SHALL cover reset mid-transfer: reset asserted during the third cycle of a LEN=4 copy. Required response: busy=0, irq=0, DONE=0, and all memory 0 immediately.

Source files
------------

// File: rtl/mmio_dma_map.sv
// mmio_dma_map: CPU-addressable word memory with a 5-word register window
// (CTRL, STATUS, SRC, DST, LEN) that drives a one-word-at-a-time DMA copy
// engine. Reads are combinational, writes commit on the rising clock edge.
// The DMA engine yields the memory write port to the CPU whenever they collide.
module mmio_dma_map #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 5,
    parameter int CTRL_BASE = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              irq,
    output logic              busy
);

    localparam int DEPTH = 2**ADDR_W;

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(CTRL_BASE);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(CTRL_BASE + 1);
    localparam logic [ADDR_W-1:0] A_SRC    = ADDR_W'(CTRL_BASE + 2);
    localparam logic [ADDR_W-1:0] A_DST    = ADDR_W'(CTRL_BASE + 3);
    localparam logic [ADDR_W-1:0] A_LEN    = ADDR_W'(CTRL_BASE + 4);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Storage
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [1:0]        r_state;
    logic              r_irq_en;
    logic              r_done;
    logic [DATA_W-1:0] r_src;
    logic [DATA_W-1:0] r_dst;
    logic [DATA_W-1:0] r_len;
    logic [DATA_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_buf;
    logic [ADDR_W-1:0] r_src_ptr;
    logic [ADDR_W-1:0] r_dst_ptr;

    // Decodes
    logic              w_busy;
    logic              w_cpu_win;
    logic              w_wr_ctrl;
    logic              w_wr_status;
    logic              w_reg_ok;
    logic              w_start;
    logic              w_len_zero;
    logic              w_last;
    logic              w_dma_wr;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] w_ctrl_rd;
    logic [DATA_W-1:0] w_status_rd;

    // True when an address falls inside the register window; such memory
    // words are shadowed and never touched by either the CPU or the DMA.
    function automatic logic in_window(input logic [ADDR_W-1:0] a);
        return (a >= A_CTRL) && (a <= A_LEN);
    endfunction

    assign w_busy      = (r_state != S_IDLE);
    assign w_cpu_win   = in_window(addr);
    assign w_wr_ctrl   = wr && (addr == A_CTRL);
    assign w_wr_status = wr && (addr == A_STATUS);
    // SRC/DST/LEN are frozen while a transfer is running
    assign w_reg_ok    = wr && !w_busy;
    // START is only honoured from IDLE
    assign w_start     = w_wr_ctrl && data_i[0] && !w_busy;
    assign w_len_zero  = (r_len == {DATA_W{1'b0}});
    assign w_last      = (r_cnt == DATA_W'(1));
    // DMA writes only when the CPU is not using the port and the target is real memory
    assign w_dma_wr    = (r_state == S_WR) && !wr && !in_window(r_dst_ptr);
    // A source pointer inside the window reads as zero
    assign w_rd_data   = in_window(r_src_ptr) ? {DATA_W{1'b0}} : r_mem[r_src_ptr];

    assign busy = w_busy;
    assign irq  = r_done && r_irq_en;

    // Assemble the readable images of CTRL and STATUS (unused bits read 0)
    always_comb begin
        w_ctrl_rd      = {DATA_W{1'b0}};
        w_status_rd    = {DATA_W{1'b0}};
        w_ctrl_rd[1]   = r_irq_en;
        w_status_rd[0] = w_busy;
        w_status_rd[1] = r_done;
    end

    // CPU read mux: register window or plain memory word
    always_comb begin
        data_o = r_mem[addr];
        case (addr)
            A_CTRL:   data_o = w_ctrl_rd;
            A_STATUS: data_o = w_status_rd;
            A_SRC:    data_o = r_src;
            A_DST:    data_o = r_dst;
            A_LEN:    data_o = r_len;
            default:  data_o = r_mem[addr];
        endcase
    end

    // DMA sequencer: IDLE -> RD -> WR (-> RD ...) -> DONE -> IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_src_ptr <= {ADDR_W{1'b0}};
            r_dst_ptr <= {ADDR_W{1'b0}};
            r_cnt     <= {DATA_W{1'b0}};
            r_buf     <= {DATA_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        if (w_len_zero) begin
                            r_state <= S_DONE;
                        end else begin
                            r_src_ptr <= ADDR_W'(r_src);
                            r_dst_ptr <= ADDR_W'(r_dst);
                            r_cnt     <= r_len;
                            r_state   <= S_RD;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RD: begin
                    r_buf   <= w_rd_data;
                    r_state <= S_WR;
                end
                S_WR: begin
                    // A CPU write owns this cycle; hold everything and retry
                    if (wr) begin
                        r_state <= S_WR;
                    end else begin
                        r_src_ptr <= r_src_ptr + ADDR_W'(1);
                        r_dst_ptr <= r_dst_ptr + ADDR_W'(1);
                        r_cnt     <= r_cnt - DATA_W'(1);
                        r_state   <= w_last ? S_DONE : S_RD;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Register window: IRQ_EN and DONE always writable, SRC/DST/LEN only when idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_src    <= {DATA_W{1'b0}};
            r_dst    <= {DATA_W{1'b0}};
            r_len    <= {DATA_W{1'b0}};
        end else begin
            if (w_wr_ctrl) begin
                r_irq_en <= data_i[1];
            end else begin
                r_irq_en <= r_irq_en;
            end

            // Completion set has priority over a coincident software clear
            if (r_state == S_DONE) begin
                r_done <= 1'b1;
            end else if (w_start && !w_len_zero) begin
                r_done <= 1'b0;
            end else if (w_wr_status && data_i[1]) begin
                r_done <= 1'b0;
            end else begin
                r_done <= r_done;
            end

            if (w_reg_ok && (addr == A_SRC)) begin
                r_src <= data_i;
            end else begin
                r_src <= r_src;
            end

            if (w_reg_ok && (addr == A_DST)) begin
                r_dst <= data_i;
            end else begin
                r_dst <= r_dst;
            end

            if (w_reg_ok && (addr == A_LEN)) begin
                r_len <= data_i;
            end else begin
                r_len <= r_len;
            end
        end
    end

    // Memory array: single write port shared by CPU (priority) and DMA
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (wr && !w_cpu_win) begin
                r_mem[addr] <= data_i;
            end else if (w_dma_wr) begin
                r_mem[r_dst_ptr] <= r_buf;
            end else begin
                r_mem[addr] <= r_mem[addr];
            end
        end
    end

endmodule

// File: tb/tb_mmio_dma_map.sv
// Directed bench for mmio_dma_map. Stimulus tasks push expected values into a
// scoreboard queue; a negedge monitor pops and compares against the DUT.
module tb_mmio_dma_map;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int CB = 16;

    localparam logic [AW-1:0] A_CTRL   = 5'd16;
    localparam logic [AW-1:0] A_STATUS = 5'd17;
    localparam logic [AW-1:0] A_SRC    = 5'd18;
    localparam logic [AW-1:0] A_DST    = 5'd19;
    localparam logic [AW-1:0] A_LEN    = 5'd20;

    localparam int SEL_DATA = 0;
    localparam int SEL_BUSY = 1;
    localparam int SEL_IRQ  = 2;
    localparam int SEL_BCNT = 3;

    logic          clk;
    logic          reset;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_i;
    logic [DW-1:0] data_o;
    logic          irq;
    logic          busy;

    typedef struct {
        string         name;
        logic [DW-1:0] exp;
        int            sel;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic [DW-1:0] mon_act;

    logic obs_req;
    int   obs_sel;
    int   busy_total;
    int   busy_mark;
    int   n_cmp;
    int   n_bad;

    mmio_dma_map #(.DATA_W(DW), .ADDR_W(AW), .CTRL_BASE(CB)) dut (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr),
        .addr   (addr),
        .data_i (data_i),
        .data_o (data_o),
        .irq    (irq),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles with busy high, sampled mid-cycle
    initial busy_total = 0;
    always @(negedge clk) begin
        if (busy === 1'b1) busy_total = busy_total + 1;
    end

    // Monitor: pop one expectation per observation request and compare
    initial begin
        n_cmp = 0;
        n_bad = 0;
    end
    always @(negedge clk) begin
        if (obs_req === 1'b1) begin
            n_cmp = n_cmp + 1;
            if (sb_q.size() == 0) begin
                n_bad = n_bad + 1;
                $display("FAIL sb_underflow: observation with no expectation queued");
            end else begin
                mon_e = sb_q.pop_front();
                case (mon_e.sel)
                    SEL_DATA: mon_act = data_o;
                    SEL_BUSY: mon_act = {7'd0, busy};
                    SEL_IRQ:  mon_act = {7'd0, irq};
                    SEL_BCNT: mon_act = DW'(busy_total - busy_mark);
                    default:  mon_act = 8'hxx;
                endcase
                if (mon_act !== mon_e.exp) begin
                    n_bad = n_bad + 1;
                    $display("FAIL %s: got %h expected %h", mon_e.name, mon_act, mon_e.exp);
                end
            end
        end
    end

    // All tasks start and end at posedge+1

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        wr      = 1'b0;
        obs_req = 1'b0;
        step();
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        obs_req = 1'b0;
        wr      = 1'b1;
        addr    = a;
        data_i  = d;
        step();
        wr      = 1'b0;
    endtask

    task automatic expect_sel(input int sel, input logic [AW-1:0] a,
                              input logic [DW-1:0] e, input string nm);
        exp_t it;
        it.name = nm;
        it.exp  = e;
        it.sel  = sel;
        wr      = 1'b0;
        addr    = a;
        obs_sel = sel;
        sb_q.push_back(it);
        obs_req = 1'b1;
        step();
        obs_req = 1'b0;
    endtask

    task automatic check_rd(input logic [AW-1:0] a, input logic [DW-1:0] e, input string nm);
        expect_sel(SEL_DATA, a, e, nm);
    endtask

    task automatic check_busy(input logic e, input string nm);
        expect_sel(SEL_BUSY, A_STATUS, {7'd0, e}, nm);
    endtask

    task automatic check_irq(input logic e, input string nm);
        expect_sel(SEL_IRQ, A_STATUS, {7'd0, e}, nm);
    endtask

    task automatic check_bcnt(input int e, input string nm);
        expect_sel(SEL_BCNT, A_STATUS, DW'(e), nm);
    endtask

    // Wait for the engine to return to IDLE; an expired budget becomes a failed check
    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((busy !== 1'b0) && (k < budget)) begin
            idle_cycle();
            k++;
        end
        if (busy !== 1'b0) check_busy(1'b0, "wait_idle_timeout");
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        wr      = 1'b0;
        addr    = '0;
        data_i  = '0;
        obs_req = 1'b0;
        obs_sel = SEL_DATA;
        busy_mark = 0;
        step();

        // Reset state
        check_busy(1'b0, "rst_busy");
        check_irq(1'b0, "rst_irq");
        check_rd(A_STATUS, 8'h00, "rst_status");
        check_rd(5'd3, 8'h00, "rst_mem3");
        reset = 1'b0;
        idle_cycle();

        // Basic copy mem[0..2] -> mem[8..10]
        cpu_write(5'd0, 8'hA1);
        cpu_write(5'd1, 8'hB2);
        cpu_write(5'd2, 8'hC3);
        cpu_write(A_SRC, 8'd0);
        cpu_write(A_DST, 8'd8);
        cpu_write(A_LEN, 8'd3);
        busy_mark = busy_total;
        cpu_write(A_CTRL, 8'h03);
        check_busy(1'b1, "copy_busy_hi");
        wait_idle(40);
        check_bcnt(7, "copy_busy_cycles");
        check_rd(5'd8,  8'hA1, "copy_mem8");
        check_rd(5'd9,  8'hB2, "copy_mem9");
        check_rd(5'd10, 8'hC3, "copy_mem10");
        check_rd(5'd11, 8'h00, "copy_mem11");
        check_rd(A_STATUS, 8'h02, "copy_status");
        check_rd(A_CTRL, 8'h02, "copy_ctrl_start_reads0");
        check_irq(1'b1, "copy_irq");
        cpu_write(A_STATUS, 8'h02);
        check_irq(1'b0, "copy_irq_cleared");
        check_rd(A_STATUS, 8'h00, "copy_status_cleared");

        // LEN = 0
        cpu_write(A_LEN, 8'd0);
        busy_mark = busy_total;
        cpu_write(A_CTRL, 8'h01);
        wait_idle(10);
        check_bcnt(1, "len0_busy_cycles");
        check_rd(A_STATUS, 8'h02, "len0_status");
        check_irq(1'b0, "len0_irq_disabled");
        check_rd(5'd8, 8'hA1, "len0_mem8");
        check_rd(5'd0, 8'hA1, "len0_mem0");

        // Wrap-around source 30,31,0 -> 4..6
        cpu_write(5'd30, 8'h11);
        cpu_write(5'd31, 8'h22);
        cpu_write(5'd0,  8'h33);
        cpu_write(A_SRC, 8'd30);
        cpu_write(A_DST, 8'd4);
        cpu_write(A_LEN, 8'd3);
        busy_mark = busy_total;
        cpu_write(A_CTRL, 8'h01);
        wait_idle(40);
        check_bcnt(7, "wrap_busy_cycles");
        check_rd(5'd3, 8'h00, "wrap_mem3");
        check_rd(5'd4, 8'h11, "wrap_mem4");
        check_rd(5'd5, 8'h22, "wrap_mem5");
        check_rd(5'd6, 8'h33, "wrap_mem6");
        check_rd(5'd7, 8'h00, "wrap_mem7");

        // CPU collision on first WR cycle of a LEN=2 copy mem[8..9] -> mem[24..25]
        cpu_write(A_SRC, 8'd8);
        cpu_write(A_DST, 8'd24);
        cpu_write(A_LEN, 8'd2);
        busy_mark = busy_total;
        cpu_write(A_CTRL, 8'h01);       // edge E0: IDLE -> RD
        check_busy(1'b1, "coll_busy_hi"); // edge E1: RD -> WR
        cpu_write(5'd12, 8'h55);          // collides with first WR cycle
        wait_idle(40);
        check_bcnt(6, "coll_busy_cycles");
        check_rd(5'd12, 8'h55, "coll_mem12");
        check_rd(5'd24, 8'hA1, "coll_mem24");
        check_rd(5'd25, 8'hB2, "coll_mem25");
        check_rd(5'd26, 8'h00, "coll_mem26");

        // Window protection + busy lockout: DST = CTRL_BASE-1
        cpu_write(A_SRC, 8'd8);
        cpu_write(A_DST, 8'd15);
        cpu_write(A_LEN, 8'd3);
        busy_mark = busy_total;
        cpu_write(A_CTRL, 8'h03);
        cpu_write(A_SRC, 8'h05);          // during RD: ignored, no stall
        wait_idle(40);
        check_bcnt(7, "win_busy_cycles");
        check_rd(5'd15, 8'hA1, "win_mem15");
        check_rd(A_CTRL,   8'h02, "win_ctrl");
        check_rd(A_STATUS, 8'h02, "win_status");
        check_rd(A_SRC,    8'h08, "win_src_locked");
        check_rd(A_DST,    8'h0F, "win_dst");
        check_rd(A_LEN,    8'h03, "win_len");
        check_irq(1'b1, "win_irq");

        // Reset during third cycle of a LEN=4 copy mem[4..7] -> mem[24..27]
        cpu_write(A_SRC, 8'd4);
        cpu_write(A_DST, 8'd24);
        cpu_write(A_LEN, 8'd4);
        cpu_write(A_CTRL, 8'h03);        // E0: -> RD
        idle_cycle();                    // E1: -> WR
        idle_cycle();                    // E2: writes mem24, -> RD
        reset = 1'b1;
        check_busy(1'b0, "rst_mid_busy");
        check_irq(1'b0, "rst_mid_irq");
        check_rd(A_STATUS, 8'h00, "rst_mid_status");
        for (int i = 0; i < 32; i++) begin
            check_rd(AW'(i), 8'h00, $sformatf("rst_mid_addr%0d", i));
        end
        reset = 1'b0;
        idle_cycle();
        check_busy(1'b0, "post_rst_busy");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
